// File: rtl/ms_reveal_pkg.sv
// Shared board geometry, column masks and FSM encoding for the minesweeper reveal engine.
package ms_reveal_pkg;

    localparam int unsigned CELLS  = 64;
    localparam int unsigned ROWS   = 8;
    localparam int unsigned COLS   = 8;
    localparam int unsigned CNT_W  = 7;
    localparam int unsigned ITER_W = 6;

    localparam logic [CELLS-1:0] COL0_MASK = 64'h0101010101010101;
    localparam logic [CELLS-1:0] COL7_MASK = 64'h8080808080808080;
    localparam logic [CELLS-1:0] ALL_ONES  = {CELLS{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_LOST   = 2'd2,
        ST_WON    = 2'd3
    } state_t;

endpackage

// File: rtl/ms_nbr_spread.sv
// Combinational 8-neighbour dilation of a 64-cell board bitmap; edges never wrap across rows.
module ms_nbr_spread
    import ms_reveal_pkg::*;
(
    input  logic [CELLS-1:0] i_seed,
    output logic [CELLS-1:0] o_nbr
);

    logic [CELLS-1:0] w_no_c0;
    logic [CELLS-1:0] w_no_c7;

    // Sources in column 7 may not move to col+1, sources in column 0 may not move to col-1.
    assign w_no_c0 = i_seed & ~COL0_MASK;
    assign w_no_c7 = i_seed & ~COL7_MASK;

    assign o_nbr = (w_no_c7 << 1) | (w_no_c0 >> 1)
                 | (i_seed  << 8) | (i_seed  >> 8)
                 | (w_no_c7 << 9) | (w_no_c0 << 7)
                 | (w_no_c7 >> 7) | (w_no_c0 >> 9);

endmodule

// File: rtl/ms_reveal.sv
// Reveal engine: flag toggles, mine hits and ring-per-cycle flood fill with win/loss tracking.
module ms_reveal
    import ms_reveal_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             start,
    input  logic             cmd_flag,
    input  logic [5:0]       pos,
    input  logic [CELLS-1:0] mine,
    input  logic [CELLS-1:0] is_zero,
    output logic [CELLS-1:0] revealed,
    output logic [CELLS-1:0] flagged,
    output logic [CNT_W-1:0] flag_cnt,
    output logic             busy,
    output logic             done,
    output logic             boom,
    output logic             won
);

    state_t            r_state;
    logic [ITER_W-1:0] r_iter;

    logic [CELLS-1:0]  w_seed;
    logic [CELLS-1:0]  w_nbr;
    logic [CELLS-1:0]  w_grow;
    logic [CELLS-1:0]  w_next_rev;

    assign w_seed     = revealed & is_zero & ~mine;
    assign w_grow     = w_nbr & ~mine & ~flagged & ~revealed;
    assign w_next_rev = revealed | w_grow;

    ms_nbr_spread u_spread (
        .i_seed (w_seed),
        .o_nbr  (w_nbr)
    );

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_state  <= ST_IDLE;
            r_iter   <= '0;
            revealed <= '0;
            flagged  <= '0;
            flag_cnt <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            boom     <= 1'b0;
            won      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (cmd_flag) begin
                            if (!revealed[pos]) begin
                                flagged[pos] <= ~flagged[pos];
                                flag_cnt     <= flagged[pos] ? flag_cnt - CNT_W'(1)
                                                             : flag_cnt + CNT_W'(1);
                            end
                            done <= 1'b1;
                        end else if (flagged[pos] || revealed[pos]) begin
                            done <= 1'b1;
                        end else if (mine[pos]) begin
                            revealed <= revealed | mine;
                            boom     <= 1'b1;
                            done     <= 1'b1;
                            r_state  <= ST_LOST;
                        end else begin
                            revealed[pos] <= 1'b1;
                            busy          <= 1'b1;
                            r_iter        <= '0;
                            r_state       <= ST_EXPAND;
                        end
                    end
                end
                ST_EXPAND: begin
                    revealed <= w_next_rev;
                    r_iter   <= r_iter + ITER_W'(1);
                    // The iteration cap only matters if mine/is_zero change mid-fill.
                    if (w_grow == '0 || r_iter == {ITER_W{1'b1}}) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                        if ((w_next_rev | mine) == ALL_ONES) begin
                            won     <= 1'b1;
                            r_state <= ST_WON;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ms_reveal.sv
// Directed bench for ms_reveal with hand-computed board bitmaps and latencies.
module tb_ms_reveal;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        start;
    logic        cmd_flag;
    logic [5:0]  pos;
    logic [63:0] mine;
    logic [63:0] is_zero;
    logic [63:0] revealed;
    logic [63:0] flagged;
    logic [6:0]  flag_cnt;
    logic        busy;
    logic        done;
    logic        boom;
    logic        won;

    int n_chk  = 0;
    int n_pass = 0;
    int lat;

    ms_reveal dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .start    (start),
        .cmd_flag (cmd_flag),
        .pos      (pos),
        .mine     (mine),
        .is_zero  (is_zero),
        .revealed (revealed),
        .flagged  (flagged),
        .flag_cnt (flag_cnt),
        .busy     (busy),
        .done     (done),
        .boom     (boom),
        .won      (won)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        start = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    // Leaves the bench 1ns after the edge that sampled start.
    task automatic issue(input logic flag, input logic [5:0] p);
        start    = 1'b1;
        cmd_flag = flag;
        pos      = p;
        tick();
        start    = 1'b0;
    endtask

    // Counts edges after the sampling edge until done is seen.
    task automatic wait_done(output int l);
        l = 0;
        while (!done && l < 200) begin
            tick();
            l++;
        end
        chk("done_timeout", 64'(done), 64'd1);
    endtask

    initial begin
        rst_n    = 1'b0;
        clear    = 1'b0;
        start    = 1'b0;
        cmd_flag = 1'b0;
        pos      = '0;
        mine     = '0;
        is_zero  = '0;
        tick();
        tick();
        chk("rst_revealed", revealed, 64'd0);
        chk("rst_flagged",  flagged,  64'd0);
        chk("rst_status",   64'({flag_cnt, busy, done, boom, won}), 64'd0);
        rst_n = 1'b1;
        tick();

        // Nonzero-count cell: one expand step, done one edge after busy rises.
        issue(1'b0, 6'd20);
        chk("nz_busy", 64'(busy), 64'd1);
        wait_done(lat);
        chk("nz_lat", 64'(lat), 64'd1);
        chk("nz_rev", revealed, 64'h0000_0000_0010_0000);
        chk("nz_won", 64'(won), 64'd0);
        issue(1'b0, 6'd20);
        chk("rerev_done", 64'(done), 64'd1);
        chk("rerev_rev", revealed, 64'h0000_0000_0010_0000);

        // Empty board, all zero cells: one ring per edge, full board at +7, done/won at +8.
        do_clear();
        is_zero = '1;
        issue(1'b0, 6'd0);
        chk("fill_r0", revealed, 64'd1);
        chk("fill_busy", 64'(busy), 64'd1);
        repeat (6) tick();
        chk("fill_r6", revealed, 64'h007F_7F7F_7F7F_7F7F);
        tick();
        chk("fill_r7", revealed, '1);
        chk("fill_busy7", 64'({busy, done}), 64'b10);
        tick();
        chk("fill_done", 64'({busy, done, won}), 64'b011);
        tick();
        chk("fill_pulse", 64'(done), 64'd0);
        issue(1'b1, 6'd9);
        chk("won_ignore", flagged, 64'd0);
        chk("won_nodone", 64'(done), 64'd0);

        // Mine at 27 with its 8 neighbours nonzero; the 3x3 obstacle forces a detour,
        // the far corner 63 is reached at step 10, so done lands 11 edges after start.
        do_clear();
        mine    = 64'h0000_0000_0800_0000;
        is_zero = 64'hFFFF_FFE3_EBE3_FFFF;
        issue(1'b0, 6'd0);
        wait_done(lat);
        chk("m27_lat", 64'(lat), 64'd11);
        chk("m27_rev", revealed, 64'hFFFF_FFFF_F7FF_FFFF);
        chk("m27_won", 64'({won, boom}), 64'b10);

        // Mine hit: whole mine map revealed at once, terminal afterwards.
        do_clear();
        mine    = 64'h0000_0100_0000_0400;
        is_zero = '0;
        issue(1'b0, 6'd10);
        chk("hit_done", 64'({done, boom, busy}), 64'b110);
        chk("hit_rev", revealed, 64'h0000_0100_0000_0400);
        issue(1'b1, 6'd3);
        chk("lost_ignore", flagged, 64'd0);
        chk("lost_nodone", 64'(done), 64'd0);

        // Flags: toggle cell 5, then wall off column 5 and fill from 0.
        do_clear();
        mine    = '0;
        is_zero = '1;
        issue(1'b1, 6'd5);
        chk("flag_on", flagged, 64'h20);
        chk("flag_cnt1", 64'(flag_cnt), 64'd1);
        chk("flag_done", 64'(done), 64'd1);
        issue(1'b1, 6'd5);
        chk("flag_off", flagged, 64'd0);
        chk("flag_cnt0", 64'(flag_cnt), 64'd0);
        for (int i = 0; i < 8; i++) issue(1'b1, 6'(5 + 8 * i));
        chk("wall_flags", flagged, 64'h2020_2020_2020_2020);
        chk("wall_cnt", 64'(flag_cnt), 64'd8);
        issue(1'b0, 6'd0);
        wait_done(lat);
        chk("wall_lat", 64'(lat), 64'd8);
        chk("wall_rev", revealed, 64'h1F1F_1F1F_1F1F_1F1F);
        chk("wall_won", 64'(won), 64'd0);
        issue(1'b0, 6'd5);
        chk("revflag_done", 64'(done), 64'd1);
        chk("revflag_rev", revealed, 64'h1F1F_1F1F_1F1F_1F1F);
        issue(1'b1, 6'd0);
        chk("flagrev_cnt", 64'(flag_cnt), 64'd8);
        chk("flagrev_flags", flagged, 64'h2020_2020_2020_2020);

        // Start while busy is dropped; clear mid-fill aborts and zeroes everything.
        do_clear();
        issue(1'b0, 6'd0);
        tick();
        chk("abort_busy", 64'(busy), 64'd1);
        issue(1'b1, 6'd63);
        tick();
        do_clear();
        chk("abort_rev", revealed, 64'd0);
        chk("abort_flags", flagged, 64'd0);
        chk("abort_status", 64'({flag_cnt, busy, done, boom, won}), 64'd0);
        tick();
        chk("abort_idle", 64'({busy, done}), 64'd0);
        issue(1'b1, 6'd63);
        chk("abort_cmd", flagged, 64'h8000_0000_0000_0000);
        chk("abort_cmd_done", 64'(done), 64'd1);

        // Row wrap: zero cells only in column 7, non-mine column-0 cells must stay covered.
        do_clear();
        mine    = 64'h0001_0001_0001_0001;
        is_zero = 64'h8080_8080_8080_8080;
        issue(1'b0, 6'd15);
        wait_done(lat);
        chk("wrap_lat", 64'(lat), 64'd7);
        chk("wrap_rev", revealed, 64'hC0C0_C0C0_C0C0_C0C0);
        chk("wrap_status", 64'({boom, won, busy}), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
